decdigi2hex_8bit: RTL
=====================

// Module: decdigi2hex_8bit
// PURPOSE
//   Converts three 7-segment decimal digit codes (hundreds/tens/units) back into an
//   8-bit binary value. Sequential shift-add accumulator, one digit per cycle.
//   Valid/ready handshake on both sides. Sits on the display/readback path as the
//   inverse of the binary-to-decimal-digit encoder, e.g. for display self-check.
// PARAMETERS
//   INVERT_SEG  0  1: segment inputs are active-low; invert before decoding
//   SAT_EN      1  1: saturate result to 8'hFF on overflow; 0: result wraps mod 256
// PORTS
//   clock      in   1  single clock; all state updates on posedge
//   rst_n      in   1  synchronous reset, active-low
//   in_valid   in   1  digi_2/1/0 hold a conversion request
//   in_ready   out  1  block can accept a request (high only in IDLE)
//   digi_2     in   7  hundreds digit, 7-seg code
//   digi_1     in   7  tens digit, 7-seg code
//   digi_0     in   7  units digit, 7-seg code
//   out_valid  out  1  hex/err_code/err_ovf valid (high only in DONE)
//   out_ready  in   1  consumer accepts the result
//   hex        out  8  binary result
//   err_code   out  1  at least one input code was not a legal digit
//   err_ovf    out  1  decoded decimal value > 255
// BEHAVIOUR
// - Reset: sampled only on posedge clock while rst_n=0; rst_n is not in the sensitivity list.
// - Reset values: state=IDLE; in_ready=1 in IDLE; out_valid=0; hex=0; err_code=0; err_ovf=0.
// - Reset wins over all other events and may occur in any state.
//   A mid-conversion reset discards the operation; no result is produced.
// - Digit code table, segment order [6:0]. The code is matched exactly.
//     0=0111111  1=0011000  2=1110110  3=1111100  4=1011001
//     5=1101101  6=1101111  7=0111000  8=1111111  9=1111101
// - Any other code is illegal and sets the error flag for that conversion.
// - FSM states: IDLE, ACC, DONE.
//   IDLE: in_ready=1.
//     On in_valid&&in_ready, capture the three codes, clear acc (10-bit), step=0, go to ACC.
//   ACC: in_ready=0.
//     Each cycle, decode the captured digit selected by step (0=hundreds, 1=tens, 2=units).
//     Update acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d in 10 bits.
//     After step 2 (third ACC cycle), register the outputs and go to DONE.
//   DONE: out_valid=1. hex/err_code/err_ovf are held stable.
//     On out_ready, go to IDLE. out_valid deasserts on that edge.
// - Latency: handshake at edge E0; out_valid=1 after edge E3 (3 cycles).
//   Minimum interval between accepted requests: 5 cycles. A new request cannot be
//   accepted in the same cycle as the output handshake.
// - Result registration (at end of ACC):
//   - Any illegal code: err_code=1, hex=0, err_ovf=0.
//   - Else if acc>255: err_ovf=1; hex=8'hFF if SAT_EN, else acc[7:0].
//   - Else: hex=acc[7:0], both error flags 0.
// - The maximum acc is 999, which fits in 10 bits. No internal wrap is possible.
// - in_valid is ignored in ACC and DONE. Input codes may change after capture without
//   affecting the result.
// - Backpressure: out_valid and the outputs stay unchanged for as long as out_ready=0.
// TESTING
// - Codes 2,5,5 -> 3 cycles after accept: out_valid=1, hex=8'hFF, err_code=0, err_ovf=0.
// - Codes 1,2,8 -> hex=8'h80. Codes 0,0,0 -> hex=8'h00. No error flags in either case.
// - Codes 2,5,6 with SAT_EN=1 -> hex=8'hFF, err_ovf=1.
//   Codes 9,9,9 with SAT_EN=0 -> hex=8'hE7 (999 mod 256), err_ovf=1.
// - Tens code 7'b0000001 (illegal) -> err_code=1, hex=8'h00, err_ovf=0.
// - out_ready=0 for 6 cycles in DONE -> out_valid and hex stay stable, in_ready=0.
//   in_valid pulsed during that window is ignored. Then out_ready=1 -> next cycle
//   IDLE, in_ready=1.
// - rst_n=0 for one edge during the second ACC cycle -> next cycle: IDLE, in_ready=1,
//   out_valid=0, hex=0. Then a fresh request 0,4,2 -> hex=8'h2A.

Source files
------------

// File: rtl/decdigi2hex_8bit_if.sv
// Request/result handshake bundle for the 7-segment readback converter.
// The master side issues digit codes and consumes the binary result.
interface decdigi2hex_8bit_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] digi_2;
    logic [6:0] digi_1;
    logic [6:0] digi_0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] hex;
    logic       err_code;
    logic       err_ovf;

    modport master (
        output in_valid, digi_2, digi_1, digi_0, out_ready,
        input  in_ready, out_valid, hex, err_code, err_ovf
    );

    modport slave (
        input  in_valid, digi_2, digi_1, digi_0, out_ready,
        output in_ready, out_valid, hex, err_code, err_ovf
    );
endinterface

// File: rtl/decdigi2hex_8bit.sv
// Converts three 7-segment decimal digit codes (hundreds/tens/units) to an 8-bit
// binary value with a shift-add accumulator consuming one digit per cycle.
module decdigi2hex_8bit #(
    parameter bit INVERT_SEG = 1'b0,
    parameter bit SAT_EN     = 1'b1
) (
    input logic                  clock,
    input logic                  rst_n,
    decdigi2hex_8bit_if.slave    bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [6:0] code_2, code_1, code_0;
    logic [9:0] acc;
    logic [1:0] step;
    logic       bad;
    logic [7:0] hex_r;
    logic       err_code_r;
    logic       err_ovf_r;

    logic [6:0] sel_code;
    logic [3:0] digit;
    logic       legal;
    logic [9:0] acc_next;
    logic       bad_next;

    always_comb begin
        sel_code = code_0;
        case (step)
            2'd0:    sel_code = code_2;
            2'd1:    sel_code = code_1;
            default: sel_code = code_0;
        endcase
    end

    // Exact-match decode; any unlisted pattern is an illegal digit.
    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (sel_code)
            7'b0111111: digit = 4'd0;
            7'b0011000: digit = 4'd1;
            7'b1110110: digit = 4'd2;
            7'b1111100: digit = 4'd3;
            7'b1011001: digit = 4'd4;
            7'b1101101: digit = 4'd5;
            7'b1101111: digit = 4'd6;
            7'b0111000: digit = 4'd7;
            7'b1111111: digit = 4'd8;
            7'b1111101: digit = 4'd9;
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + {6'd0, digit};
        bad_next = bad | ~legal;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state      <= IDLE;
            code_2     <= '0;
            code_1     <= '0;
            code_0     <= '0;
            acc        <= '0;
            step       <= '0;
            bad        <= 1'b0;
            hex_r      <= '0;
            err_code_r <= 1'b0;
            err_ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        code_2 <= INVERT_SEG ? ~bus.digi_2 : bus.digi_2;
                        code_1 <= INVERT_SEG ? ~bus.digi_1 : bus.digi_1;
                        code_0 <= INVERT_SEG ? ~bus.digi_0 : bus.digi_0;
                        acc    <= '0;
                        step   <= '0;
                        bad    <= 1'b0;
                        state  <= ACC;
                    end
                end
                ACC: begin
                    acc  <= acc_next;
                    bad  <= bad_next;
                    step <= step + 2'd1;
                    if (step == 2'd2) begin
                        state <= DONE;
                        if (bad_next) begin
                            hex_r      <= '0;
                            err_code_r <= 1'b1;
                            err_ovf_r  <= 1'b0;
                        end else if (acc_next > 10'd255) begin
                            hex_r      <= SAT_EN ? 8'hFF : acc_next[7:0];
                            err_code_r <= 1'b0;
                            err_ovf_r  <= 1'b1;
                        end else begin
                            hex_r      <= acc_next[7:0];
                            err_code_r <= 1'b0;
                            err_ovf_r  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.hex       = hex_r;
    assign bus.err_code  = err_code_r;
    assign bus.err_ovf   = err_ovf_r;
endmodule
